per_regbank_slave: RTL and testbench
====================================

Name: per_regbank_slave

Overview:
- Peripheral-interconnect slave that consumes the per_master_* request/response channel produced by the APB-to-peripheral adapter.
- Implements a bank of N_REGS 32-bit read/write registers with byte-enable writes and a fixed, parameterised response latency.
- Flags out-of-range accesses on r_opc.
- Exposes all register contents and per-register write strobes to the surrounding peripheral logic.

Parameters:
PER_ADDR_WIDTH  32  width of per_slave_add_i
N_REGS  16  number of 32-bit registers, 1..256, need not be a power of two
RD_LATENCY  1  cycles from grant cycle to r_valid pulse, 1..15

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
per_slave_req_i  in  1  request valid
per_slave_add_i  in  PER_ADDR_WIDTH  byte address
per_slave_we_i  in  1  1 = write, 0 = read
per_slave_wdata_i  in  32  write data
per_slave_be_i  in  4  byte enables, bit k covers wdata[8k+7:8k]
per_slave_gnt_o  out  1  grant, combinational
per_slave_r_valid_o  out  1  response valid, one-cycle pulse
per_slave_r_opc_o  out  1  0 = ok, 1 = error (index out of range)
per_slave_r_rdata_o  out  32  read data
regs_o  out  32*N_REGS  flattened register contents; reg i at [32i+31:32i]
wr_pulse_o  out  N_REGS  one-cycle strobe, bit i set in the cycle after reg i is written

Behaviour:
- Reset: all registers 0; r_valid 0; r_opc 0; r_rdata 0; wr_pulse_o 0; FSM in IDLE; latency counter 0.
- Decode: IDXW = max(1, clog2(N_REGS)). idx = add[IDXW+1:2]. Address bits [1:0] and bits above IDXW+1 are ignored. idx >= N_REGS is out of range.
- FSM states: IDLE, WAIT, RESP.
- Grant: gnt_o = req_i && state == IDLE. Purely combinational, no dependency on we/add. Only one transaction outstanding. No grant in WAIT or RESP.
- Grant cycle (req & gnt):
  - Write, in range: on the clock edge, reg[idx] byte k <= wdata byte k for each be[k]=1. wr_pulse_o[idx] = 1 in the next cycle, even if be = 0.
  - Read, in range: capture reg[idx] into the response register on the edge.
  - Out of range: no register change, no strobe; capture opc = 1 and rdata = 0.
  - Writes capture rdata = 0, opc per range check.
  - Transition: RD_LATENCY == 1 -> RESP; otherwise -> WAIT with counter = RD_LATENCY-1.
- WAIT: decrement the counter each cycle; at counter == 1 -> RESP.
- RESP: r_valid_o = 1 for exactly one cycle, with the captured rdata/opc -> IDLE. A new request can be granted in the cycle after RESP at the earliest.
- Response outputs:
  - r_valid is a registered output, asserted in the state RESP.
  - Outside RESP, rdata and opc hold their last values; r_valid = 0.
  - Reads and writes both produce exactly one r_valid.
- Read-after-write to the same index in back-to-back transactions returns the new value.
- req_i deasserted with no grant: no effect. The slave never requires req to be held beyond the grant cycle.
- Reset mid-transaction (WAIT/RESP): return to IDLE immediately, with no r_valid pulse. Registers are cleared.
- wr_pulse_o is registered; at most one bit set per cycle.
- Throughput: one transaction per RD_LATENCY+1 cycles.

Test Plan:
1. Reset, RD_LATENCY=1 -> gnt_o=1 while req_i=1 in IDLE; r_valid=0, regs_o all 0, wr_pulse_o=0.
2. Write add=0x08, wdata=0xA5A5_1234, be=4'b0101, then read 0x08 -> reg2=0x00A5_0034; wr_pulse_o=16'h0004 for one cycle; read r_valid 1 cycle after grant, rdata=0x00A5_0034, opc=0.
3. N_REGS=5, read add=0x1C (idx 7) -> opc=1, rdata=0, regs unchanged. Write add=0x14 (idx 5) -> opc=1, no strobe, regs unchanged.
4. RD_LATENCY=4, req held high continuously for reads of 0x0 then 0x4 -> grants at cycles 0 and 5, r_valid at cycles 4 and 9, gnt_o=0 in cycles 1-4.
5. Assert rst_ni low while in WAIT (RD_LATENCY=3) -> no r_valid ever issued, regs cleared, gnt_o=1 on first cycle after release with req=1.
6. Write 0xFFFF_FFFF be=4'hF to add=0x3C, then read add=0x13C (upper bits ignored) -> rdata=0xFFFF_FFFF, opc=0.

Source files
------------

// File: rtl/per_regbank_slave.sv
// Register bank slave on the per_master request/response channel.
// One outstanding transaction; response issued RD_LATENCY cycles after grant.
module per_regbank_slave #(
  parameter int unsigned PER_ADDR_WIDTH = 32,
  parameter int unsigned N_REGS         = 16,
  parameter int unsigned RD_LATENCY     = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      per_slave_req_i,
  input  logic [PER_ADDR_WIDTH-1:0] per_slave_add_i,
  input  logic                      per_slave_we_i,
  input  logic [31:0]               per_slave_wdata_i,
  input  logic [3:0]                per_slave_be_i,
  output logic                      per_slave_gnt_o,
  output logic                      per_slave_r_valid_o,
  output logic                      per_slave_r_opc_o,
  output logic [31:0]               per_slave_r_rdata_o,
  output logic [32*N_REGS-1:0]      regs_o,
  output logic [N_REGS-1:0]         wr_pulse_o
);

  localparam int unsigned IDXW = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam int unsigned CNTW = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              r_valid_q, r_valid_d;
  logic              r_opc_q, r_opc_d;
  logic [31:0]       r_rdata_q, r_rdata_d;
  logic [N_REGS-1:0] wr_pulse_q, wr_pulse_d;
  logic [31:0]       regs_q [N_REGS];
  logic [31:0]       regs_d [N_REGS];

  logic [IDXW-1:0]   idx_c;
  logic [31:0]       idx_ext_c;
  logic              in_range_c;
  logic              unused_add_c;

  // Word index; byte offset and upper address bits are don't-care.
  assign idx_c        = per_slave_add_i[IDXW+1:2];
  assign idx_ext_c    = 32'(idx_c);
  assign in_range_c   = (idx_ext_c < N_REGS);
  assign unused_add_c = ^per_slave_add_i;

  assign per_slave_gnt_o     = per_slave_req_i && (state_q == IDLE);
  assign per_slave_r_valid_o = r_valid_q;
  assign per_slave_r_opc_o   = r_opc_q;
  assign per_slave_r_rdata_o = r_rdata_q;
  assign wr_pulse_o          = wr_pulse_q;

  always_comb begin
    for (int unsigned i = 0; i < N_REGS; i++) begin
      regs_o[32*i +: 32] = regs_q[i];
    end
  end

  // Next-state, register write and response capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    r_valid_d  = 1'b0;
    r_opc_d    = r_opc_q;
    r_rdata_d  = r_rdata_q;
    wr_pulse_d = '0;
    for (int unsigned i = 0; i < N_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end

    unique case (state_q)
      IDLE: begin
        if (per_slave_req_i) begin
          r_opc_d   = ~in_range_c;
          r_rdata_d = '0;
          for (int unsigned i = 0; i < N_REGS; i++) begin
            if (in_range_c && (idx_ext_c == i)) begin
              if (per_slave_we_i) begin
                wr_pulse_d[i] = 1'b1;
                for (int unsigned k = 0; k < 4; k++) begin
                  if (per_slave_be_i[k]) begin
                    regs_d[i][8*k +: 8] = per_slave_wdata_i[8*k +: 8];
                  end
                end
              end else begin
                r_rdata_d = regs_q[i];
              end
            end
          end
          if (RD_LATENCY == 1) begin
            state_d   = RESP;
            r_valid_d = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNTW'(RD_LATENCY - 1);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) begin
          state_d   = RESP;
          r_valid_d = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      r_valid_q  <= 1'b0;
      r_opc_q    <= 1'b0;
      r_rdata_q  <= '0;
      wr_pulse_q <= '0;
      for (int unsigned i = 0; i < N_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      r_valid_q  <= r_valid_d;
      r_opc_q    <= r_opc_d;
      r_rdata_q  <= r_rdata_d;
      wr_pulse_q <= wr_pulse_d;
      for (int unsigned i = 0; i < N_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

endmodule

// File: tb/tb_per_regbank_slave.sv
// Directed bench for per_regbank_slave: three instances covering
// single-cycle latency, a non-power-of-two bank, and reset during WAIT.
module tb_per_regbank_slave;

  logic         clk;
  logic         rst_n, rst_c_n;
  logic         req_a, req_b, req_c;
  logic [31:0]  add;
  logic         we;
  logic [31:0]  wdata;
  logic [3:0]   be;

  logic         gnt_a, rv_a, opc_a;
  logic [31:0]  rdata_a;
  logic [511:0] regs_a;
  logic [15:0]  wrp_a;

  logic         gnt_b, rv_b, opc_b;
  logic [31:0]  rdata_b;
  logic [159:0] regs_b;
  logic [4:0]   wrp_b;

  logic         gnt_c, rv_c, opc_c;
  logic [31:0]  rdata_c;
  logic [511:0] regs_c;
  logic [15:0]  wrp_c;

  int n_cmp;
  int n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  per_regbank_slave #(.PER_ADDR_WIDTH(32), .N_REGS(16), .RD_LATENCY(1)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .per_slave_req_i(req_a), .per_slave_add_i(add),
    .per_slave_we_i(we), .per_slave_wdata_i(wdata), .per_slave_be_i(be),
    .per_slave_gnt_o(gnt_a), .per_slave_r_valid_o(rv_a), .per_slave_r_opc_o(opc_a),
    .per_slave_r_rdata_o(rdata_a), .regs_o(regs_a), .wr_pulse_o(wrp_a));

  per_regbank_slave #(.PER_ADDR_WIDTH(32), .N_REGS(5), .RD_LATENCY(4)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .per_slave_req_i(req_b), .per_slave_add_i(add),
    .per_slave_we_i(we), .per_slave_wdata_i(wdata), .per_slave_be_i(be),
    .per_slave_gnt_o(gnt_b), .per_slave_r_valid_o(rv_b), .per_slave_r_opc_o(opc_b),
    .per_slave_r_rdata_o(rdata_b), .regs_o(regs_b), .wr_pulse_o(wrp_b));

  per_regbank_slave #(.PER_ADDR_WIDTH(32), .N_REGS(16), .RD_LATENCY(3)) u_c (
    .clk_i(clk), .rst_ni(rst_n & rst_c_n), .per_slave_req_i(req_c), .per_slave_add_i(add),
    .per_slave_we_i(we), .per_slave_wdata_i(wdata), .per_slave_be_i(be),
    .per_slave_gnt_o(gnt_c), .per_slave_r_valid_o(rv_c), .per_slave_r_opc_o(opc_c),
    .per_slave_r_rdata_o(rdata_c), .regs_o(regs_c), .wr_pulse_o(wrp_c));

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // One transaction on instance B; starts and ends at a negedge with B idle.
  task automatic xact_b(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, output logic got, output logic [31:0] rd,
                        output logic op, output logic [4:0] pul);
    req_b = 1'b1; we = w; add = a; wdata = d; be = b;
    got = 1'b0; rd = '0; op = 1'b0; pul = '0;
    @(negedge clk);
    req_b = 1'b0;
    for (int i = 0; i < 20; i++) begin
      pul |= wrp_b;
      if (rv_b && !got) begin
        got = 1'b1; rd = rdata_b; op = opc_b;
      end
      if (got) break;
      @(negedge clk);
    end
    @(negedge clk);
    pul |= wrp_b;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst_c_n = 1'b1;
    req_a = 0; req_b = 0; req_c = 0; we = 0; add = '0; wdata = '0; be = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (rv_a !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid got=%b exp=0", rv_a); end
    n_cmp++; if (rdata_a !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got=%h exp=0", rdata_a); end
    n_cmp++; if (opc_a !== 1'b0) begin n_bad++; $display("FAIL reset_opc got=%b exp=0", opc_a); end
    n_cmp++; if (regs_a !== 512'h0) begin n_bad++; $display("FAIL reset_regs got=%h exp=0", regs_a); end
    n_cmp++; if (wrp_a !== 16'h0) begin n_bad++; $display("FAIL reset_wrpulse got=%h exp=0", wrp_a); end
    rst_n = 1'b1;
    @(negedge clk);
    req_a = 1'b1; we = 1'b0; add = 32'h0;
    #1;
    n_cmp++; if (gnt_a !== 1'b1) begin n_bad++; $display("FAIL reset_gnt got=%b exp=1", gnt_a); end
    @(negedge clk);
    req_a = 1'b0;
    n_cmp++; if (rv_a !== 1'b1) begin n_bad++; $display("FAIL first_read_rvalid got=%b exp=1", rv_a); end
    n_cmp++; if (rdata_a !== 32'h0) begin n_bad++; $display("FAIL first_read_rdata got=%h exp=0", rdata_a); end
    @(negedge clk);
    n_cmp++; if (rv_a !== 1'b0) begin n_bad++; $display("FAIL rvalid_one_cycle got=%b exp=0", rv_a); end
  endtask

  task automatic test_write_read();
    req_a = 1'b1; we = 1'b1; add = 32'h08; wdata = 32'hA5A5_1234; be = 4'b0101;
    #1;
    n_cmp++; if (gnt_a !== 1'b1) begin n_bad++; $display("FAIL wr_gnt got=%b exp=1", gnt_a); end
    @(negedge clk);
    req_a = 1'b0; we = 1'b0;
    n_cmp++; if (rv_a !== 1'b1) begin n_bad++; $display("FAIL wr_rvalid got=%b exp=1", rv_a); end
    n_cmp++; if (rdata_a !== 32'h0) begin n_bad++; $display("FAIL wr_rdata got=%h exp=0", rdata_a); end
    n_cmp++; if (opc_a !== 1'b0) begin n_bad++; $display("FAIL wr_opc got=%b exp=0", opc_a); end
    n_cmp++; if (wrp_a !== 16'h0004) begin n_bad++; $display("FAIL wr_pulse got=%h exp=0004", wrp_a); end
    n_cmp++; if (regs_a[95:64] !== 32'h00A5_0034) begin n_bad++; $display("FAIL wr_reg2 got=%h exp=00a50034", regs_a[95:64]); end
    @(negedge clk);
    n_cmp++; if (wrp_a !== 16'h0) begin n_bad++; $display("FAIL wr_pulse_clear got=%h exp=0", wrp_a); end
    req_a = 1'b1; add = 32'h08;
    @(negedge clk);
    req_a = 1'b0;
    n_cmp++; if (rv_a !== 1'b1) begin n_bad++; $display("FAIL rd_rvalid got=%b exp=1", rv_a); end
    n_cmp++; if (rdata_a !== 32'h00A5_0034) begin n_bad++; $display("FAIL rd_rdata got=%h exp=00a50034", rdata_a); end
    n_cmp++; if (opc_a !== 1'b0) begin n_bad++; $display("FAIL rd_opc got=%b exp=0", opc_a); end
    n_cmp++; if (wrp_a !== 16'h0) begin n_bad++; $display("FAIL rd_no_pulse got=%h exp=0", wrp_a); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    req_a = 1'b1; we = 1'b1; add = 32'h0C; wdata = 32'h1122_3344; be = 4'hF;
    @(negedge clk);
    we = 1'b0;
    #1;
    n_cmp++; if (gnt_a !== 1'b0) begin n_bad++; $display("FAIL b2b_gnt_resp got=%b exp=0", gnt_a); end
    n_cmp++; if (rv_a !== 1'b1) begin n_bad++; $display("FAIL b2b_wr_rvalid got=%b exp=1", rv_a); end
    @(negedge clk);
    #1;
    n_cmp++; if (gnt_a !== 1'b1) begin n_bad++; $display("FAIL b2b_gnt_idle got=%b exp=1", gnt_a); end
    @(negedge clk);
    req_a = 1'b0;
    n_cmp++; if (rv_a !== 1'b1) begin n_bad++; $display("FAIL b2b_rd_rvalid got=%b exp=1", rv_a); end
    n_cmp++; if (rdata_a !== 32'h1122_3344) begin n_bad++; $display("FAIL b2b_rd_rdata got=%h exp=11223344", rdata_a); end
    @(negedge clk);
  endtask

  task automatic test_upper_bits();
    req_a = 1'b1; we = 1'b1; add = 32'h3C; wdata = 32'hFFFF_FFFF; be = 4'hF;
    @(negedge clk);
    req_a = 1'b0;
    @(negedge clk);
    req_a = 1'b1; we = 1'b0; add = 32'h13C;
    @(negedge clk);
    req_a = 1'b0;
    n_cmp++; if (rv_a !== 1'b1) begin n_bad++; $display("FAIL alias_rvalid got=%b exp=1", rv_a); end
    n_cmp++; if (rdata_a !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL alias_rdata got=%h exp=ffffffff", rdata_a); end
    n_cmp++; if (opc_a !== 1'b0) begin n_bad++; $display("FAIL alias_opc got=%b exp=0", opc_a); end
    n_cmp++; if (regs_a[511:480] !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL alias_reg15 got=%h exp=ffffffff", regs_a[511:480]); end
    @(negedge clk);
  endtask

  task automatic test_out_of_range();
    logic got, op;
    logic [31:0] rd;
    logic [4:0] pul;
    xact_b(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, got, rd, op, pul);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL oor_wr4_resp got=%b exp=1", got); end
    n_cmp++; if (op !== 1'b0) begin n_bad++; $display("FAIL oor_wr4_opc got=%b exp=0", op); end
    n_cmp++; if (pul !== 5'b10000) begin n_bad++; $display("FAIL oor_wr4_pulse got=%b exp=10000", pul); end
    xact_b(1'b0, 32'h1C, 32'h0, 4'hF, got, rd, op, pul);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL oor_rd_resp got=%b exp=1", got); end
    n_cmp++; if (op !== 1'b1) begin n_bad++; $display("FAIL oor_rd_opc got=%b exp=1", op); end
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL oor_rd_rdata got=%h exp=0", rd); end
    xact_b(1'b1, 32'h14, 32'hFFFF_FFFF, 4'hF, got, rd, op, pul);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL oor_wr_resp got=%b exp=1", got); end
    n_cmp++; if (op !== 1'b1) begin n_bad++; $display("FAIL oor_wr_opc got=%b exp=1", op); end
    n_cmp++; if (pul !== 5'b00000) begin n_bad++; $display("FAIL oor_wr_pulse got=%b exp=00000", pul); end
    n_cmp++; if (regs_b !== {32'hDEAD_BEEF, 128'h0}) begin n_bad++; $display("FAIL oor_regs got=%h", regs_b); end
    xact_b(1'b1, 32'h0, 32'hFFFF_FFFF, 4'h0, got, rd, op, pul);
    n_cmp++; if (pul !== 5'b00001) begin n_bad++; $display("FAIL be0_pulse got=%b exp=00001", pul); end
    n_cmp++; if (regs_b !== {32'hDEAD_BEEF, 128'h0}) begin n_bad++; $display("FAIL be0_regs got=%h", regs_b); end
  endtask

  task automatic test_latency();
    logic got, op;
    logic [31:0] rd;
    logic [4:0] pul;
    logic exp_g, exp_v;
    logic [31:0] exp_d;
    xact_b(1'b1, 32'h0, 32'h0000_1111, 4'hF, got, rd, op, pul);
    xact_b(1'b1, 32'h4, 32'h2222_0000, 4'hF, got, rd, op, pul);
    for (int t = 0; t < 10; t++) begin
      req_b = (t < 9);
      we = 1'b0;
      add = (t < 5) ? 32'h0 : 32'h4;
      #1;
      exp_g = (t == 0) || (t == 5);
      exp_v = (t == 4) || (t == 9);
      exp_d = (t == 4) ? 32'h0000_1111 : 32'h2222_0000;
      n_cmp++; if (gnt_b !== exp_g) begin n_bad++; $display("FAIL lat_gnt cyc=%0d got=%b exp=%b", t, gnt_b, exp_g); end
      n_cmp++; if (rv_b !== exp_v) begin n_bad++; $display("FAIL lat_rvalid cyc=%0d got=%b exp=%b", t, rv_b, exp_v); end
      if (exp_v) begin
        n_cmp++; if (rdata_b !== exp_d) begin n_bad++; $display("FAIL lat_rdata cyc=%0d got=%h exp=%h", t, rdata_b, exp_d); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_wait();
    int nv;
    logic [31:0] rd;
    req_c = 1'b1; we = 1'b1; add = 32'h0C; wdata = 32'h0000_CAFE; be = 4'hF;
    @(negedge clk);
    req_c = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (regs_c[127:96] !== 32'h0000_CAFE) begin n_bad++; $display("FAIL rstw_pre_reg3 got=%h exp=0000cafe", regs_c[127:96]); end
    req_c = 1'b1; we = 1'b0; add = 32'h0C;
    @(negedge clk);
    req_c = 1'b0;
    rst_c_n = 1'b0;
    #1;
    n_cmp++; if (regs_c !== 512'h0) begin n_bad++; $display("FAIL rstw_regs_clear got=%h", regs_c); end
    nv = 0;
    repeat (3) begin
      @(negedge clk);
      if (rv_c) nv++;
    end
    n_cmp++; if (nv !== 0) begin n_bad++; $display("FAIL rstw_no_rvalid got=%0d exp=0", nv); end
    rst_c_n = 1'b1; req_c = 1'b1; add = 32'h0C;
    #1;
    n_cmp++; if (gnt_c !== 1'b1) begin n_bad++; $display("FAIL rstw_gnt_after got=%b exp=1", gnt_c); end
    @(negedge clk);
    req_c = 1'b0;
    nv = 0; rd = 32'hFFFF_FFFF;
    for (int i = 0; i < 6; i++) begin
      if (rv_c) begin nv++; rd = rdata_c; end
      @(negedge clk);
    end
    n_cmp++; if (nv !== 1) begin n_bad++; $display("FAIL rstw_resp_count got=%0d exp=1", nv); end
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL rstw_rd_cleared got=%h exp=0", rd); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0; rst_c_n = 1'b1;
    req_a = 0; req_b = 0; req_c = 0; we = 0; add = '0; wdata = '0; be = '0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_upper_bits();
    test_out_of_range();
    test_latency();
    test_reset_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
